// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the CPU (port 0)
// and the pattern-matcher memory master (port 1). CPU has priority; a wait
// counter forces a port 1 grant after MAX_WAIT consecutive denied cycles.
module dmem_arbiter #(
   parameter int unsigned MAX_WAIT  = 4,
   parameter logic [31:0] MEM_LIMIT = 32'h0004_0000
) (
   input  logic        clk,
   input  logic        reset,
   // port 0 (CPU)
   input  logic        req0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic [3:0]  we0,
   output logic        gnt0,
   output logic [31:0] rdata0,
   output logic        rvalid0,
   output logic        err0,
   // port 1 (peripheral)
   input  logic        req1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   input  logic [3:0]  we1,
   output logic        gnt1,
   output logic [31:0] rdata1,
   output logic        rvalid1,
   output logic        err1,
   // dmem side
   output logic [31:0] daddr,
   output logic [31:0] dwdata,
   output logic [3:0]  dwe,
   input  logic [31:0] drdata
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 32;

   // Last cycle's owner; routes the response pulse and error flag.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   wait_q, wait_d;
   logic               err_q, err_d;
   logic [DATA_W-1:0]  rdata0_q, rdata0_d;
   logic [DATA_W-1:0]  rdata1_q, rdata1_d;
   logic               sel_err;

   // State, starvation counter, error flag and per-port read data registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         wait_q   <= '0;
         err_q    <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         err_q    <= err_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // Grant selection, dmem mux, next owner, wait counter and read capture.
   always_comb begin
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      daddr    = '0;
      dwdata   = '0;
      dwe      = '0;
      sel_err  = 1'b0;
      state_d  = IDLE;
      wait_d   = '0;
      err_d    = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;

      if (req1 && ((wait_q == CNT_W'(MAX_WAIT)) || !req0)) begin
         gnt1 = 1'b1;
      end else if (req0) begin
         gnt0 = 1'b1;
      end

      // Out-of-range accesses are still granted but can never write.
      if (gnt0) begin
         sel_err  = (addr0 >= MEM_LIMIT);
         daddr    = {addr0[31:2], 2'b00};
         dwdata   = wdata0;
         dwe      = sel_err ? 4'b0000 : we0;
         state_d  = OWN0;
         rdata0_d = sel_err ? '0 : drdata;
      end else if (gnt1) begin
         sel_err  = (addr1 >= MEM_LIMIT);
         daddr    = {addr1[31:2], 2'b00};
         dwdata   = wdata1;
         dwe      = sel_err ? 4'b0000 : we1;
         state_d  = OWN1;
         rdata1_d = sel_err ? '0 : drdata;
      end
      err_d = sel_err;

      // Count consecutive denied cycles of a pending port 1 request.
      if (req1 && !gnt1) begin
         wait_d = (wait_q >= CNT_W'(MAX_WAIT)) ? wait_q : wait_q + CNT_W'(1);
      end

      // No grant and no write strobe may escape while reset is held.
      if (!reset) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
         dwe  = 4'b0000;
      end
   end

   assign rvalid0 = (state_q == OWN0);
   assign rvalid1 = (state_q == OWN1);
   assign err0    = rvalid0 & err_q;
   assign err1    = rvalid1 & err_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios for the two-port dmem arbiter with a
// small behavioural dmem (async read, byte-masked write on posedge).
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [3:0]  we0, we1;
   logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] daddr, dwdata, drdata;
   logic [3:0]  dwe;

   logic [31:0] mem [0:4095];
   logic [31:0] saved;
   int          checks = 0;
   int          errors = 0;

   dmem_arbiter #(.MAX_WAIT(4), .MEM_LIMIT(32'h0004_0000)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
      .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0), .err0(err0),
      .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
      .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1), .err1(err1),
      .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
   );

   always #5 clk = ~clk;

   // Behavioural dmem: word index from byte address, async read.
   assign drdata = mem[daddr[13:2]];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (dwe[b]) mem[daddr[13:2]][b*8 +: 8] <= dwdata[b*8 +: 8];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      req0 = r; addr0 = a; wdata0 = d; we0 = w;
   endtask

   task automatic set1(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      req1 = r; addr1 = a; wdata1 = d; we1 = w;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set0(1'b0, 32'h0, 32'h0, 4'h0);
      set1(1'b0, 32'h0, 32'h0, 4'h0);
      #12;
      checks++;
      if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, dwe} !== 10'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, dwe});
      end
      checks++;
      if ({rdata0, rdata1} !== 64'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %h expected 0", {rdata0, rdata1});
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      set0(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
      #1;
      checks++;
      if ({gnt0, gnt1, dwe, daddr, dwdata} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL wr_grant: gnt0=%b gnt1=%b dwe=%h daddr=%h dwdata=%h expected 1 0 f 100 deadbeef",
                  gnt0, gnt1, dwe, daddr, dwdata);
      end
      tick();
      checks++;
      if ({rvalid0, err0, rvalid1} !== 3'b100) begin
         errors++;
         $display("FAIL wr_rvalid: rvalid0/err0/rvalid1=%b expected 100", {rvalid0, err0, rvalid1});
      end
      set0(1'b1, 32'h100, 32'h0, 4'h0);
      #1;
      checks++;
      if ({gnt0, dwe} !== 5'b1_0000) begin
         errors++;
         $display("FAIL rd_grant: gnt0=%b dwe=%h expected 1 0", gnt0, dwe);
      end
      tick();
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_data: rvalid0=%b rdata0=%h expected 1 deadbeef", rvalid0, rdata0);
      end
      set0(1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      checks++;
      if (rvalid0 !== 1'b0 || rdata0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_hold: rvalid0=%b rdata0=%h expected 0 deadbeef", rvalid0, rdata0);
      end
   endtask

   task automatic test_byte_write();
      set0(1'b1, 32'h200, 32'h11223344, 4'hF);
      tick();
      set0(1'b0, 32'h0, 32'h0, 4'h0);
      set1(1'b1, 32'h200, 32'h0000AB00, 4'b0010);
      #1;
      checks++;
      if ({gnt0, gnt1, dwe} !== 6'b01_0010) begin
         errors++;
         $display("FAIL bw_grant: gnt0=%b gnt1=%b dwe=%b expected 0 1 0010", gnt0, gnt1, dwe);
      end
      tick();
      checks++;
      if ({rvalid1, err1, rvalid0} !== 3'b100) begin
         errors++;
         $display("FAIL bw_rvalid: rvalid1/err1/rvalid0=%b expected 100", {rvalid1, err1, rvalid0});
      end
      set1(1'b1, 32'h200, 32'h0, 4'h0);
      tick();
      checks++;
      if (rvalid1 !== 1'b1 || rdata1 !== 32'h1122AB44) begin
         errors++;
         $display("FAIL bw_read: rvalid1=%b rdata1=%h expected 1 1122ab44", rvalid1, rdata1);
      end
      set1(1'b0, 32'h0, 32'h0, 4'h0);
      tick();
   endtask

   task automatic test_starvation();
      set0(1'b1, 32'h100, 32'h0, 4'h0);
      set1(1'b1, 32'h200, 32'h0, 4'h0);
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if (gnt1 !== 1'((i % 5) == 4) || gnt0 !== 1'((i % 5) != 4)) begin
            errors++;
            $display("FAIL starve_gnt[%0d]: gnt0=%b gnt1=%b expected %b %b",
                     i, gnt0, gnt1, 1'((i % 5) != 4), 1'((i % 5) == 4));
         end
         tick();
         checks++;
         if (rvalid1 !== 1'((i % 5) == 4) || rvalid0 !== 1'((i % 5) != 4)) begin
            errors++;
            $display("FAIL starve_rvalid[%0d]: rvalid0=%b rvalid1=%b", i, rvalid0, rvalid1);
         end
      end
      checks++;
      if (rdata1 !== 32'h1122AB44 || rdata0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL starve_data: rdata0=%h rdata1=%h expected deadbeef 1122ab44", rdata0, rdata1);
      end
      set0(1'b0, 32'h0, 32'h0, 4'h0);
      set1(1'b0, 32'h0, 32'h0, 4'h0);
      tick();
   endtask

   task automatic test_range();
      saved = mem[0];
      set0(1'b1, 32'h0004_0000, 32'h12345678, 4'hF);
      #1;
      checks++;
      if (gnt0 !== 1'b1 || dwe !== 4'h0) begin
         errors++;
         $display("FAIL oor_grant: gnt0=%b dwe=%h expected 1 0", gnt0, dwe);
      end
      tick();
      checks++;
      if ({rvalid0, err0} !== 2'b11 || rdata0 !== 32'h0 || mem[0] !== saved) begin
         errors++;
         $display("FAIL oor_resp: rvalid0=%b err0=%b rdata0=%h mem0=%h expected 1 1 0 %h",
                  rvalid0, err0, rdata0, mem[0], saved);
      end
      set0(1'b0, 32'h0, 32'h0, 4'h0);
      set1(1'b1, 32'h0007_FFFC, 32'h0, 4'h0);
      tick();
      checks++;
      if ({rvalid1, err1} !== 2'b11 || rdata1 !== 32'h0) begin
         errors++;
         $display("FAIL oor_p1: rvalid1=%b err1=%b rdata1=%h expected 1 1 0", rvalid1, err1, rdata1);
      end
      set1(1'b0, 32'h0, 32'h0, 4'h0);
      set0(1'b1, 32'h0003_FFFC, 32'h0BADCAFE, 4'hF);
      #1;
      checks++;
      if (dwe !== 4'hF) begin
         errors++;
         $display("FAIL edge_dwe: dwe=%h expected f", dwe);
      end
      tick();
      checks++;
      if ({rvalid0, err0} !== 2'b10) begin
         errors++;
         $display("FAIL edge_err: rvalid0=%b err0=%b expected 1 0", rvalid0, err0);
      end
      set0(1'b0, 32'h0, 32'h0, 4'h0);
      tick();
   endtask

   task automatic test_reset_mid();
      set0(1'b1, 32'h300, 32'h55555555, 4'hF);
      tick();
      // build up wait count to 2 before the reset
      set0(1'b1, 32'h100, 32'h0, 4'h0);
      set1(1'b1, 32'h200, 32'h0, 4'h0);
      tick();
      tick();
      set0(1'b1, 32'h300, 32'hCAFEF00D, 4'hF);
      #1;
      checks++;
      if (gnt0 !== 1'b1 || dwe !== 4'hF) begin
         errors++;
         $display("FAIL rst_pre: gnt0=%b dwe=%h expected 1 f", gnt0, dwe);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, dwe} !== 10'b0 || {rdata0, rdata1} !== 64'h0) begin
         errors++;
         $display("FAIL rst_mid: ctrl=%b rdata0=%h rdata1=%h expected 0",
                  {gnt0, gnt1, rvalid0, rvalid1, err0, err1, dwe}, rdata0, rdata1);
      end
      tick();
      checks++;
      if (mem[12'h0C0] !== 32'h55555555) begin
         errors++;
         $display("FAIL rst_nowrite: mem[300]=%h expected 55555555", mem[12'h0C0]);
      end
      set0(1'b1, 32'h300, 32'h0, 4'h0);
      #2;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (gnt1 !== 1'(i == 4) || gnt0 !== 1'(i != 4)) begin
            errors++;
            $display("FAIL rst_after[%0d]: gnt0=%b gnt1=%b expected %b %b",
                     i, gnt0, gnt1, 1'(i != 4), 1'(i == 4));
         end
         tick();
      end
      checks++;
      if (rdata0 !== 32'h55555555) begin
         errors++;
         $display("FAIL rst_rdata: rdata0=%h expected 55555555", rdata0);
      end
      set0(1'b0, 32'h0, 32'h0, 4'h0);
      set1(1'b0, 32'h0, 32'h0, 4'h0);
      tick();
   endtask

   task automatic test_back_to_back();
      set0(1'b1, 32'h100, 32'h0, 4'h0);
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_g0: gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1);
      end
      tick();
      set0(1'b0, 32'h0, 32'h0, 4'h0);
      set1(1'b1, 32'h200, 32'h0, 4'h0);
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL b2b_r0: rvalid0=%b rdata0=%h expected 1 deadbeef", rvalid0, rdata0);
      end
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_g1: gnt0=%b gnt1=%b expected 0 1", gnt0, gnt1);
      end
      tick();
      checks++;
      if ({rvalid0, rvalid1} !== 2'b01 || rdata1 !== 32'h1122AB44) begin
         errors++;
         $display("FAIL b2b_r1: rvalid0=%b rvalid1=%b rdata1=%h expected 0 1 1122ab44",
                  rvalid0, rvalid1, rdata1);
      end
      set1(1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      checks++;
      if ({rvalid0, rvalid1} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_idle: rvalid0=%b rvalid1=%b expected 0 0", rvalid0, rvalid1);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_write();
      test_starvation();
      test_range();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
